// File: rtl/crs_client.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : crs_client                                                    |
// | Description : Host command client for a bus master. It issues single write,|
// |               read and bulk-write-commit requests, waits for the ack       |
// |               handshake or aborts on timeout, and holds a bulk-write FIFO   |
// |               that the master drains with buf_rd_i.                         |
// | Ports       : clk, rst (sync, active-high)                                  |
// |               cmd_valid_i/cmd_ready_o/cmd_op_i/cmd_adr_i/cmd_data_i : host  |
// |               fill_wr_i/fill_adr_i/fill_data_i/fill_full_o/ovf_o : FIFO fill|
// |               rsp_valid_o/rsp_data_o/rsp_err_o : completion                 |
// |               wr_req_o/rd_req_o/bwr_req_o/ack_i/adr_o/wr_data_o/rd_data_i : |
// |               master request side                                          |
// |               buf_rd_i/buf_empty_o/buf_wr_data_o : FIFO drain               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module crs_client #(
  parameter int DEPTH_LOG2 = 4,
  parameter int TIMEOUT    = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [1:0]  cmd_op_i,
  input  logic [11:0] cmd_adr_i,
  input  logic [15:0] cmd_data_i,
  input  logic        fill_wr_i,
  input  logic [11:0] fill_adr_i,
  input  logic [15:0] fill_data_i,
  output logic        fill_full_o,
  output logic        ovf_o,
  output logic        rsp_valid_o,
  output logic [15:0] rsp_data_o,
  output logic        rsp_err_o,
  output logic        wr_req_o,
  output logic        rd_req_o,
  output logic        bwr_req_o,
  input  logic        ack_i,
  output logic [11:0] adr_o,
  output logic [15:0] wr_data_o,
  input  logic [15:0] rd_data_i,
  input  logic        buf_rd_i,
  output logic        buf_empty_o,
  output logic [31:0] buf_wr_data_o
);

  localparam int DEPTH  = 1 << DEPTH_LOG2;
  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_REL  = 2'd2;

  localparam logic [1:0] OP_WR   = 2'd0;
  localparam logic [1:0] OP_RD   = 2'd1;
  localparam logic [1:0] OP_BWR  = 2'd2;
  localparam logic [1:0] OP_RSVD = 2'd3;

  localparam logic [DEPTH_LOG2:0] C_FULL      = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [WAIT_W-1:0]   C_WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  logic [1:0]            state_q, state_d;
  logic [1:0]            op_q, op_d;
  logic                  wr_req_q, wr_req_d, rd_req_q, rd_req_d, bwr_req_q, bwr_req_d;
  logic                  rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [15:0]           rsp_data_q, rsp_data_d;
  logic [11:0]           adr_q, adr_d;
  logic [15:0]           wr_data_q, wr_data_d;
  logic [WAIT_W-1:0]     wait_q, wait_d;
  logic [DEPTH_LOG2-1:0] wptr_q, rptr_q;
  logic [DEPTH_LOG2:0]   cnt_q;
  logic                  ovf_q, ovf_d;
  logic [31:0]           buf_q;
  logic [31:0]           mem_q [DEPTH];

  logic cmd_fire, wait_last, push, pop;

  assign cmd_fire  = cmd_valid_i && (state_q == S_IDLE);
  // The abort edge is the one on which the counter would reach TIMEOUT.
  assign wait_last = (wait_q == C_WAIT_LAST);

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (cmd_fire && (cmd_op_i != OP_RSVD)) state_d = S_REQ;
      S_REQ:   if (ack_i) state_d = S_REL;
               else if (wait_last) state_d = S_IDLE;
      S_REL:   if (!ack_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs (next values of the registered request/response outputs)
  always_comb begin
    op_d        = op_q;
    wr_req_d    = wr_req_q;
    rd_req_d    = rd_req_q;
    bwr_req_d   = bwr_req_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_data_d  = rsp_data_q;
    adr_d       = adr_q;
    wr_data_d   = wr_data_q;
    wait_d      = wait_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_fire) begin
          op_d       = cmd_op_i;
          rsp_data_d = 16'h0000;
          if (cmd_op_i == OP_RSVD) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            adr_d     = cmd_adr_i;
            wr_data_d = cmd_data_i;
            wait_d    = '0;
            wr_req_d  = (cmd_op_i == OP_WR);
            rd_req_d  = (cmd_op_i == OP_RD);
            bwr_req_d = (cmd_op_i == OP_BWR);
          end
        end
      end
      S_REQ: begin
        if (ack_i) begin
          if (op_q == OP_RD) rsp_data_d = rd_data_i;
          wr_req_d  = 1'b0;
          rd_req_d  = 1'b0;
          bwr_req_d = 1'b0;
        end else begin
          wait_d = wait_q + 1'b1;
          if (wait_last) begin
            wr_req_d    = 1'b0;
            rd_req_d    = 1'b0;
            bwr_req_d   = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end
        end
      end
      S_REL: begin
        if (!ack_i) rsp_valid_d = 1'b1;
      end
      default: begin
        wr_req_d  = 1'b0;
        rd_req_d  = 1'b0;
        bwr_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q        <= OP_WR;
      wr_req_q    <= 1'b0;
      rd_req_q    <= 1'b0;
      bwr_req_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= 16'h0000;
      adr_q       <= 12'h000;
      wr_data_q   <= 16'h0000;
      wait_q      <= '0;
    end else begin
      op_q        <= op_d;
      wr_req_q    <= wr_req_d;
      rd_req_q    <= rd_req_d;
      bwr_req_q   <= bwr_req_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
      adr_q       <= adr_d;
      wr_data_q   <= wr_data_d;
      wait_q      <= wait_d;
    end
  end

  // Bulk-write FIFO. Filling is blocked while a commit is outstanding so the
  // master drains a stable snapshot.
  assign fill_full_o = (cnt_q == C_FULL) ||
                       (((state_q == S_REQ) || (state_q == S_REL)) && (op_q == OP_BWR));
  assign push        = fill_wr_i && !fill_full_o;
  assign pop         = buf_rd_i && (cnt_q != '0);
  // A drop on the commit edge itself is still reported.
  assign ovf_d       = (ovf_q && !(cmd_fire && (cmd_op_i == OP_BWR))) ||
                       (fill_wr_i && fill_full_o);

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      buf_q  <= 32'h0;
    end else begin
      ovf_q <= ovf_d;
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop) begin
        rptr_q <= rptr_q + 1'b1;
        buf_q  <= mem_q[rptr_q];
      end
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset; the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= {4'h0, fill_adr_i, fill_data_i};
  end

  assign cmd_ready_o   = (state_q == S_IDLE);
  assign ovf_o         = ovf_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_err_o     = rsp_err_q;
  assign rsp_data_o    = rsp_data_q;
  assign wr_req_o      = wr_req_q;
  assign rd_req_o      = rd_req_q;
  assign bwr_req_o     = bwr_req_q;
  assign adr_o         = adr_q;
  assign wr_data_o     = wr_data_q;
  assign buf_empty_o   = (cnt_q == '0);
  assign buf_wr_data_o = buf_q;

endmodule
`default_nettype wire

// File: tb/tb_crs_client.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_crs_client                                                 |
// | Description : Directed self-checking bench for crs_client. A second        |
// |               instance with TIMEOUT=8 shares the stimulus and is observed  |
// |               for the abort case.                                          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_crs_client;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid_i;
  logic [1:0]  cmd_op_i;
  logic [11:0] cmd_adr_i;
  logic [15:0] cmd_data_i;
  logic        fill_wr_i;
  logic [11:0] fill_adr_i;
  logic [15:0] fill_data_i;
  logic        ack_i;
  logic [15:0] rd_data_i;
  logic        buf_rd_i;

  logic        cmd_ready_o, fill_full_o, ovf_o, rsp_valid_o, rsp_err_o;
  logic [15:0] rsp_data_o, wr_data_o;
  logic        wr_req_o, rd_req_o, bwr_req_o, buf_empty_o;
  logic [11:0] adr_o;
  logic [31:0] buf_wr_data_o;

  logic        t_cmd_ready, t_fill_full, t_ovf, t_rsp_valid, t_rsp_err;
  logic [15:0] t_rsp_data, t_wr_data;
  logic        t_wr_req, t_rd_req, t_bwr_req, t_buf_empty;
  logic [11:0] t_adr;
  logic [31:0] t_buf_wr_data;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  crs_client #(.DEPTH_LOG2(4), .TIMEOUT(1023)) u_dut (
    .clk(clk), .rst(rst),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_op_i(cmd_op_i),
    .cmd_adr_i(cmd_adr_i), .cmd_data_i(cmd_data_i),
    .fill_wr_i(fill_wr_i), .fill_adr_i(fill_adr_i), .fill_data_i(fill_data_i),
    .fill_full_o(fill_full_o), .ovf_o(ovf_o),
    .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o),
    .wr_req_o(wr_req_o), .rd_req_o(rd_req_o), .bwr_req_o(bwr_req_o),
    .ack_i(ack_i), .adr_o(adr_o), .wr_data_o(wr_data_o), .rd_data_i(rd_data_i),
    .buf_rd_i(buf_rd_i), .buf_empty_o(buf_empty_o), .buf_wr_data_o(buf_wr_data_o)
  );

  crs_client #(.DEPTH_LOG2(4), .TIMEOUT(8)) u_dut_to (
    .clk(clk), .rst(rst),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(t_cmd_ready), .cmd_op_i(cmd_op_i),
    .cmd_adr_i(cmd_adr_i), .cmd_data_i(cmd_data_i),
    .fill_wr_i(fill_wr_i), .fill_adr_i(fill_adr_i), .fill_data_i(fill_data_i),
    .fill_full_o(t_fill_full), .ovf_o(t_ovf),
    .rsp_valid_o(t_rsp_valid), .rsp_data_o(t_rsp_data), .rsp_err_o(t_rsp_err),
    .wr_req_o(t_wr_req), .rd_req_o(t_rd_req), .bwr_req_o(t_bwr_req),
    .ack_i(ack_i), .adr_o(t_adr), .wr_data_o(t_wr_data), .rd_data_i(rd_data_i),
    .buf_rd_i(buf_rd_i), .buf_empty_o(t_buf_empty), .buf_wr_data_o(t_buf_wr_data)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic [1:0] op, input logic [11:0] a, input logic [15:0] d);
    cmd_valid_i = 1'b1;
    cmd_op_i    = op;
    cmd_adr_i   = a;
    cmd_data_i  = d;
    tick();
    cmd_valid_i = 1'b0;
  endtask

  task automatic fill(input logic [11:0] a, input logic [15:0] d);
    fill_wr_i   = 1'b1;
    fill_adr_i  = a;
    fill_data_i = d;
    tick();
    fill_wr_i   = 1'b0;
  endtask

  task automatic pop1();
    buf_rd_i = 1'b1;
    tick();
    buf_rd_i = 1'b0;
  endtask

  function automatic logic [31:0] ent(input int i);
    return {4'h0, 12'(12'h100 + i), 16'(16'hA000 + i)};
  endfunction

  // Requests are mutually exclusive and never present while the block is idle.
  always @(negedge clk) begin
    if (!rst) begin
      n_vec++;
      assert ($onehot0({wr_req_o, rd_req_o, bwr_req_o}) &&
              !((wr_req_o || rd_req_o || bwr_req_o) && cmd_ready_o)) else begin
        n_err++;
        $error("FAIL req_excl: observed wr/rd/bwr=%b%b%b ready=%b, expected onehot0 and not idle",
               wr_req_o, rd_req_o, bwr_req_o, cmd_ready_o);
      end
    end
  end

  initial begin
    logic seen;
    rst = 1'b1; cmd_valid_i = 1'b0; cmd_op_i = 2'd0; cmd_adr_i = 12'h0; cmd_data_i = 16'h0;
    fill_wr_i = 1'b0; fill_adr_i = 12'h0; fill_data_i = 16'h0;
    ack_i = 1'b0; rd_data_i = 16'h0; buf_rd_i = 1'b0;
    tick();
    tick();

    // Reset state
    chk("rst_ready_empty_full", {cmd_ready_o, buf_empty_o, fill_full_o, ovf_o}, 4'b1100);
    chk("rst_rsp_req", {rsp_valid_o, rsp_err_o, wr_req_o, rd_req_o, bwr_req_o}, 5'b0);
    chk("rst_regs", {rsp_data_o, adr_o, wr_data_o}, 44'h0);
    chk("rst_bufdata", buf_wr_data_o, 32'h0);
    chk("rst_to_flags", {t_cmd_ready, t_buf_empty, t_fill_full, t_ovf, t_rsp_valid, t_rsp_err,
                         t_wr_req, t_rd_req, t_bwr_req}, 9'b110000000);
    chk("rst_to_regs", {t_rsp_data, t_adr, t_wr_data}, 44'h0);
    chk("rst_to_bufdata", t_buf_wr_data, 32'h0);
    rst = 1'b0;
    tick();

    // Single write, ack 3 cycles after the request, held 2 cycles
    cmd(2'd0, 12'h123, 16'hBEEF);
    chk("wr_req_set", {wr_req_o, rd_req_o, bwr_req_o, cmd_ready_o}, 4'b1000);
    chk("wr_latch", {adr_o, wr_data_o}, {12'h123, 16'hBEEF});
    tick();
    tick();
    chk("wr_req_hold", wr_req_o, 1'b1);
    ack_i = 1'b1;
    tick();
    chk("wr_req_drop", {wr_req_o, rsp_valid_o}, 2'b00);
    tick();
    chk("wr_wait_ack_low", rsp_valid_o, 1'b0);
    ack_i = 1'b0;
    tick();
    chk("wr_rsp", {rsp_valid_o, rsp_err_o, cmd_ready_o}, 3'b101);
    tick();
    chk("wr_rsp_pulse", rsp_valid_o, 1'b0);

    // Read
    cmd(2'd1, 12'h010, 16'h0000);
    chk("rd_req_only", {wr_req_o, rd_req_o, bwr_req_o}, 3'b010);
    chk("rd_adr", adr_o, 12'h010);
    ack_i = 1'b1; rd_data_i = 16'h5A5A;
    tick();
    chk("rd_req_drop", rd_req_o, 1'b0);
    ack_i = 1'b0; rd_data_i = 16'h0000;
    tick();
    chk("rd_rsp", {rsp_valid_o, rsp_err_o, rsp_data_o}, {2'b10, 16'h5A5A});
    tick();

    // Reserved op
    cmd(2'd3, 12'h0FF, 16'h1234);
    chk("op3_rsp", {rsp_valid_o, rsp_err_o, cmd_ready_o, rsp_data_o}, {3'b111, 16'h0});
    chk("op3_noreq", {wr_req_o, rd_req_o, bwr_req_o}, 3'b000);
    tick();
    chk("op3_pulse", rsp_valid_o, 1'b0);

    // Bulk write: 3 entries, commit, 3 pops 3 cycles apart, then ack
    fill(12'h001, 16'h1111);
    fill(12'h002, 16'h2222);
    fill(12'h003, 16'h3333);
    chk("bulk_filled", {buf_empty_o, fill_full_o}, 2'b00);
    cmd(2'd2, 12'h000, 16'h0000);
    chk("bulk_req", {wr_req_o, rd_req_o, bwr_req_o, fill_full_o}, 4'b0011);
    pop1();
    chk("bulk_pop1", buf_wr_data_o, 32'h00011111);
    tick();
    tick();
    chk("bulk_hold", buf_wr_data_o, 32'h00011111);
    pop1();
    chk("bulk_pop2", buf_wr_data_o, 32'h00022222);
    tick();
    tick();
    pop1();
    chk("bulk_pop3", {buf_empty_o, buf_wr_data_o}, {1'b1, 32'h00033333});
    chk("bulk_req_still", bwr_req_o, 1'b1);
    ack_i = 1'b1;
    tick();
    chk("bulk_release", {bwr_req_o, fill_full_o}, 2'b01);
    ack_i = 1'b0;
    tick();
    chk("bulk_rsp", {rsp_valid_o, rsp_err_o, fill_full_o}, 3'b100);
    pop1();
    chk("empty_pop_ignored", {buf_empty_o, buf_wr_data_o}, {1'b1, 32'h00033333});

    // Full / overflow
    for (int i = 0; i < 16; i++) begin
      fill(12'(12'h100 + i), 16'(16'hA000 + i));
      if (i == 14) chk("full_at15", fill_full_o, 1'b0);
    end
    chk("full_at16", {fill_full_o, ovf_o}, 2'b10);
    fill(12'h110, 16'hA010);
    chk("ovf_set", {fill_full_o, ovf_o}, 2'b11);
    cmd(2'd2, 12'h000, 16'h0000);
    chk("ovf_clr", {ovf_o, bwr_req_o}, 2'b01);
    ack_i = 1'b1;
    tick();
    ack_i = 1'b0;
    tick();
    chk("full_commit_rsp", {rsp_valid_o, rsp_err_o}, 2'b10);
    for (int i = 0; i < 11; i++) begin
      pop1();
      chk($sformatf("drain_%0d", i), buf_wr_data_o, ent(i));
    end
    // count is now 5: simultaneous push and pop
    fill_wr_i = 1'b1; fill_adr_i = 12'h120; fill_data_i = 16'hA020;
    buf_rd_i  = 1'b1;
    tick();
    fill_wr_i = 1'b0; buf_rd_i = 1'b0;
    chk("pushpop_data", buf_wr_data_o, ent(11));
    for (int i = 12; i < 16; i++) begin
      pop1();
      chk($sformatf("tail_%0d", i), buf_wr_data_o, ent(i));
    end
    chk("tail_not_empty", buf_empty_o, 1'b0);
    pop1();
    chk("tail_last", {buf_empty_o, buf_wr_data_o}, {1'b1, ent(32)});

    // Timeout on the TIMEOUT=8 instance
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cmd(2'd0, 12'h0AA, 16'h1234);
    chk("to_req", {t_wr_req, t_cmd_ready}, 2'b10);
    for (int k = 1; k < 8; k++) tick();
    chk("to_req_7", {t_wr_req, t_rsp_valid}, 2'b10);
    tick();
    chk("to_abort", {t_wr_req, t_rsp_valid, t_rsp_err, t_cmd_ready}, 4'b0111);
    tick();
    chk("to_pulse", {t_rsp_valid, t_rsp_err}, 2'b00);

    // Reset in the middle of a bulk commit
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) fill(12'(12'h200 + i), 16'(16'hB000 + i));
    cmd(2'd2, 12'h000, 16'h0000);
    chk("mid_req", {bwr_req_o, buf_empty_o}, 2'b10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst", {wr_req_o, rd_req_o, bwr_req_o, buf_empty_o, rsp_valid_o, fill_full_o},
        6'b000100);
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      seen = seen | rsp_valid_o;
    end
    chk("mid_no_rsp", {seen, cmd_ready_o, buf_empty_o}, 3'b011);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
